// File: rtl/spi_master.sv
// SPI master that sends a 2-bit command plus an 8-bit payload as a framed, MSB-first word.
// A read-data command (cmd=11) also waits MISO_LAT cycles and then captures one byte from MISO.
module spi_master #(
    parameter int unsigned MISO_LAT = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_i,
    input  logic [1:0] cmd_i,
    input  logic [7:0] din_i,
    input  logic       miso_i,
    output logic       ss_n_o,
    output logic       mosi_o,
    output logic       busy_o,
    output logic       done_o,
    output logic [7:0] rd_data_o,
    output logic       rd_valid_o
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SELECT  = 3'd1,
        S_CMD     = 3'd2,
        S_SHIFT   = 3'd3,
        S_WAIT    = 3'd4,
        S_CAPTURE = 3'd5,
        S_END     = 3'd6
    } state_e;

    // The counter holds the frame cycle through SELECT..SHIFT; it restarts at WAIT and keeps running through CAPTURE.
    localparam logic [4:0] SHIFT_LAST = 5'd11;
    localparam logic [4:0] WAIT_LAST  = 5'(MISO_LAT - 1);
    localparam logic [4:0] CAP_LAST   = 5'(MISO_LAT + 7);

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [9:0]  sh_q, sh_d;
    logic        rd_frame_q, rd_frame_d;
    logic [7:0]  rx_q, rx_d;
    logic        ss_n_q, ss_n_d;
    logic        mosi_q, mosi_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [7:0]  rd_data_q, rd_data_d;
    logic        rd_valid_q, rd_valid_d;

    // State register and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= 5'd0;
            sh_q       <= 10'd0;
            rd_frame_q <= 1'b0;
            rx_q       <= 8'h00;
            ss_n_q     <= 1'b1;
            mosi_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rd_data_q  <= 8'h00;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sh_q       <= sh_d;
            rd_frame_q <= rd_frame_d;
            rx_q       <= rx_d;
            ss_n_q     <= ss_n_d;
            mosi_q     <= mosi_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // Next state and next output values; outputs are computed for the cycle being entered.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sh_d       = sh_q;
        rd_frame_d = rd_frame_q;
        rx_d       = rx_q;
        ss_n_d     = 1'b1;
        mosi_d     = 1'b0;
        done_d     = 1'b0;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d    = S_SELECT;
                    cnt_d      = 5'd0;
                    sh_d       = {cmd_i, din_i};
                    rd_frame_d = (cmd_i == 2'b11);
                    ss_n_d     = 1'b0;
                    mosi_d     = cmd_i[1];
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SELECT: begin
                state_d = S_CMD;
                cnt_d   = cnt_q + 5'd1;
                ss_n_d  = 1'b0;
                mosi_d  = sh_q[9];
            end
            S_CMD: begin
                state_d = S_SHIFT;
                cnt_d   = cnt_q + 5'd1;
                ss_n_d  = 1'b0;
                mosi_d  = sh_q[9];
            end
            S_SHIFT: begin
                if (cnt_q == SHIFT_LAST) begin
                    if (rd_frame_q) begin
                        state_d = S_WAIT;
                        cnt_d   = 5'd0;
                        ss_n_d  = 1'b0;
                    end else begin
                        state_d = S_END;
                        done_d  = 1'b1;
                    end
                end else begin
                    cnt_d  = cnt_q + 5'd1;
                    sh_d   = {sh_q[8:0], 1'b0};
                    ss_n_d = 1'b0;
                    mosi_d = sh_q[8];
                end
            end
            S_WAIT: begin
                cnt_d  = cnt_q + 5'd1;
                ss_n_d = 1'b0;
                if (cnt_q == WAIT_LAST) begin
                    state_d = S_CAPTURE;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_CAPTURE: begin
                rx_d = {rx_q[6:0], miso_i};
                if (cnt_q == CAP_LAST) begin
                    state_d    = S_END;
                    done_d     = 1'b1;
                    rd_valid_d = 1'b1;
                    rd_data_d  = {rx_q[6:0], miso_i};
                end else begin
                    cnt_d  = cnt_q + 5'd1;
                    ss_n_d = 1'b0;
                end
            end
            S_END: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    assign ss_n_o     = ss_n_q;
    assign mosi_o     = mosi_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign rd_data_o  = rd_data_q;
    assign rd_valid_o = rd_valid_q;

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master: frame-level reference model plus a RAM-backed slave decoding MOSI.
module tb_spi_master;

    localparam int LAT = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [1:0] cmd = 2'b00;
    logic [7:0] din = 8'h00;
    logic       miso = 1'b0;
    logic       ss_n, mosi, busy, done, rd_valid;
    logic [7:0] rd_data;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] ref_ram [256];
    logic [7:0] ref_addr = 8'h00;
    logic [7:0] last_rd = 8'h00;
    logic [7:0] slv_ram [256];
    logic [7:0] slv_addr = 8'h00;

    spi_master #(.MISO_LAT(LAT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start),
        .cmd_i      (cmd),
        .din_i      (din),
        .miso_i     (miso),
        .ss_n_o     (ss_n),
        .mosi_o     (mosi),
        .busy_o     (busy),
        .done_o     (done),
        .rd_data_o  (rd_data),
        .rd_valid_o (rd_valid)
    );

    always #5 clk = ~clk;

    // Runs one frame starting at the current negedge; checks every cycle up to and including END.
    task automatic run_frame(input logic [1:0] c, input logic [7:0] d, input bit keep_start,
                             input int pulse_at, input int abort_at);
        logic [9:0]  word;
        logic [9:0]  seen;
        logic [7:0]  resp;
        logic [7:0]  exp_byte;
        logic [12:0] got;
        logic [12:0] exp;
        logic        e_ss;
        logic        e_mosi;
        logic        is_end;
        logic        is_rd;
        int          len;
        word     = {c, d};
        seen     = 10'd0;
        resp     = 8'h00;
        exp_byte = 8'h00;
        is_rd    = (c == 2'b11);
        len      = is_rd ? 20 + LAT : 12;
        case (c)
            2'b01:   ref_ram[ref_addr] = d;
            2'b11:   exp_byte = ref_ram[ref_addr];
            default: ref_addr = d;
        endcase
        start = 1'b1;
        cmd   = c;
        din   = d;
        for (int n = 0; n <= len; n++) begin
            @(negedge clk);
            if (n == 0 && !keep_start) start = 1'b0;
            if (pulse_at >= 0 && n == pulse_at) start = 1'b1;
            if (pulse_at >= 0 && n == pulse_at + 1) start = 1'b0;
            if (n == abort_at) begin
                rst_n = 1'b0;
                #1;
                n_cmp++;
                got = {ss_n, mosi, busy, done, rd_valid, rd_data};
                exp = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
                if (got !== exp) begin
                    n_bad++;
                    $display("FAIL abort_reset cyc %0d: {ss,mosi,busy,done,rv,rd} got %b want %b", n, got, exp);
                end
                last_rd = 8'h00;
                return;
            end
            // Slave side: collect the 10 MOSI bits, decode, and answer read-data frames.
            if (n >= 2 && n <= 11) seen[11 - n] = mosi;
            if (n == 11) begin
                case (seen[9:8])
                    2'b01:   slv_ram[slv_addr] = seen[7:0];
                    2'b11:   resp = slv_ram[slv_addr];
                    default: slv_addr = seen[7:0];
                endcase
            end
            if (seen[9:8] == 2'b11 && n >= 12 + LAT && n <= 19 + LAT) miso = resp[19 + LAT - n];
            else miso = 1'($urandom_range(0, 1));

            e_ss   = (n < len) ? 1'b0 : 1'b1;
            if (n <= 1) e_mosi = c[1];
            else if (n <= 11) e_mosi = word[11 - n];
            else e_mosi = 1'b0;
            is_end = (n == len);
            exp = {e_ss, e_mosi, 1'b1, is_end, is_end & is_rd, (is_end && is_rd) ? exp_byte : last_rd};
            got = {ss_n, mosi, busy, done, rd_valid, rd_data};
            n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL frame cmd=%b din=%h cyc %0d: {ss,mosi,busy,done,rv,rd} got %b want %b",
                         c, d, n, got, exp);
            end
        end
        if (is_rd) last_rd = exp_byte;
    endtask

    task automatic test_reset();
        logic [12:0] got;
        rst_n = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);
        got = {ss_n, mosi, busy, done, rd_valid, rd_data};
        n_cmp++;
        if (got !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00}) begin
            n_bad++;
            $display("FAIL reset_state: got %b want 1000000000000", got);
        end
        rst_n = 1'b1;
        run_frame(2'b00, 8'hC3, 1'b0, -1, -1);
    endtask

    task automatic test_write();
        run_frame(2'b00, 8'hA5, 1'b0, -1, -1);
        @(negedge clk);
        run_frame(2'b01, 8'h5A, 1'b0, -1, -1);
        @(negedge clk);
    endtask

    task automatic test_read_data();
        run_frame(2'b00, 8'h42, 1'b0, -1, -1);
        @(negedge clk);
        run_frame(2'b01, 8'h3C, 1'b0, -1, -1);
        @(negedge clk);
        run_frame(2'b10, 8'h42, 1'b0, -1, -1);
        @(negedge clk);
        run_frame(2'b11, 8'h00, 1'b0, -1, -1);
        n_cmp++;
        if (rd_data !== 8'h3C || rd_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL read_3c: rd_data=%h rv=%b want 3c/1", rd_data, rd_valid);
        end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (rd_data !== 8'h3C || rd_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL read_hold: rd_data=%h rv=%b want 3c/0", rd_data, rd_valid);
        end
    endtask

    task automatic test_busy_ignore();
        run_frame(2'b01, 8'h96, 1'b0, 5, -1);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            n_cmp++;
            if ({ss_n, busy, done} !== 3'b100) begin
                n_bad++;
                $display("FAIL busy_ignore idle %0d: {ss,busy,done} got %b want 100", k, {ss_n, busy, done});
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] c;
        logic [7:0] d;
        run_frame(2'b00, 8'h81, 1'b1, -1, -1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_cmp++;
            if ({ss_n, busy, done} !== 3'b100) begin
                n_bad++;
                $display("FAIL b2b_gap %0d: {ss,busy,done} got %b want 100", k, {ss_n, busy, done});
            end
            c = 2'($urandom_range(0, 3));
            d = 8'($urandom);
            run_frame(c, d, 1'b1, -1, -1);
        end
        start = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_read();
        run_frame(2'b11, 8'h00, 1'b0, -1, 16);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_cmp++;
            if ({ss_n, busy, done, rd_valid, rd_data} !== {4'b1000, 8'h00}) begin
                n_bad++;
                $display("FAIL reset_hold %0d: got %b", k, {ss_n, busy, done, rd_valid, rd_data});
            end
        end
        rst_n = 1'b1;
        run_frame(2'b00, 8'h5A, 1'b0, -1, -1);
        @(negedge clk);
    endtask

    task automatic test_system();
        run_frame(2'b00, 8'h10, 1'b0, -1, -1);
        @(negedge clk);
        run_frame(2'b01, 8'h77, 1'b0, -1, -1);
        @(negedge clk);
        run_frame(2'b10, 8'h10, 1'b0, -1, -1);
        @(negedge clk);
        run_frame(2'b11, 8'h00, 1'b0, -1, -1);
        n_cmp++;
        if (rd_data !== 8'h77) begin
            n_bad++;
            $display("FAIL system_loop: rd_data=%h want 77", rd_data);
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        for (int k = 0; k < 30; k++) begin
            run_frame(2'($urandom_range(0, 3)), 8'($urandom), 1'b0, -1, -1);
            repeat ($urandom_range(1, 3)) @(negedge clk);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            ref_ram[i] = 8'h00;
            slv_ram[i] = 8'h00;
        end
        @(negedge clk);
        test_reset();
        @(negedge clk);
        test_write();
        test_read_data();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid_read();
        test_system();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 The block SHALL have one clock, clk; reset SHALL be rst_n, asynchronous and active-low.
REQ-002 Parameter: MISO_LAT, default 2, SHALL be the cycle count from the last MOSI data bit to the first MISO bit (legal 1..7).
REQ-003 clk  input  1  system clock; SS_n/MOSI launch and MISO sampling SHALL be on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 start  input  1  request a frame; sampled only in IDLE.
REQ-006 cmd  input  2  command: 00 write addr, 01 write data, 10 read addr, 11 read data.
REQ-007 din  input  8  address/data payload, captured with start.
REQ-008 MISO  input  1  serial data from slave.
REQ-009 SS_n  output  1  active-low slave select, registered.
REQ-010 MOSI  output  1  serial data to slave, registered, MSB first.
REQ-011 busy  output  1  high whenever state != IDLE.
REQ-012 done  output  1  one-cycle pulse at frame end.
REQ-013 rd_data  output  8  byte captured on MISO during a cmd=11 frame.
REQ-014 rd_valid  output  1  one-cycle pulse, coincident with done, only for cmd=11.

Function
REQ-015 States SHALL be IDLE, SELECT, CMD, SHIFT, WAIT, CAPTURE, END.
REQ-016 In IDLE, start=1 at an edge SHALL latch word={cmd,din} and move to SELECT; frame cycle 0 SHALL be the next cycle.
REQ-017 start SHALL be ignored while busy=1; no queueing.
REQ-018 SS_n SHALL be 0 from frame cycle 0 through the last frame cycle before END, and 1 in END and IDLE.
REQ-019 MOSI SHALL be cmd[1] in frame cycles 0 (SELECT) and 1 (CMD).
REQ-020 MOSI SHALL be word[9-(n-2)] in frame cycles n=2..11 (SHIFT), i.e. 10 bits MSB first.
REQ-021 For cmd!=11, END SHALL be frame cycle 12.
REQ-022 For cmd=11, WAIT SHALL span cycles 12..11+MISO_LAT with MOSI=0.
REQ-023 For cmd=11, CAPTURE SHALL sample MISO at the end of cycles 12+MISO_LAT..19+MISO_LAT into rd_data MSB first.
REQ-024 For cmd=11, END SHALL be cycle 20+MISO_LAT.
REQ-025 rd_data SHALL update only at the transition into END of a cmd=11 frame and SHALL hold otherwise.
REQ-026 MOSI SHALL be 0 in IDLE, WAIT, CAPTURE and END.
REQ-027 done SHALL be 1 exactly in the END cycle; END SHALL always return to IDLE next cycle.
REQ-028 Minimum SS_n-high gap between frames SHALL be 2 cycles: END plus the IDLE cycle that accepts start.
REQ-029 The bit counter SHALL be 5 bits wide and SHALL clear on entry to SELECT and on entry to WAIT.

Reset
REQ-030 While rst_n=0, asynchronously: state=IDLE, SS_n=1, MOSI=0, busy=0, done=0, rd_valid=0, rd_data=8'h00, counters=0.
REQ-031 Reset mid-frame SHALL abort the frame with no done or rd_valid pulse; SS_n SHALL rise immediately.
REQ-032 After reset release, the first start SHALL be accepted on the first edge with rst_n=1.

Verification
REQ-033 Write frame: start with cmd=00, din=8'hA5 -> SS_n low cycles 0..11; MOSI cycles 2..11 = 0,0,1,0,1,0,0,1,0,1; done at cycle 12; rd_valid=0.
REQ-034 Read data: cmd=11, MISO_LAT=2, slave model returns 8'h3C on cycles 14..21 -> rd_data=8'h3C, rd_valid=done=1 at cycle 22, SS_n=1 at cycle 22.
REQ-035 Start while busy: pulse start at cycle 5 of a write frame -> ignored; exactly one done; next frame only on a new start in IDLE.
REQ-036 Back-to-back: start held high -> SS_n high for exactly 2 cycles between frames; MOSI payloads match each latched din.
REQ-037 Reset mid-read: rst_n=0 at cycle 16 of a cmd=11 frame -> SS_n=1 and rd_data=8'h00 immediately; no done; after release, a write of 8'h5A completes normally.
REQ-038 Full system loop: write addr 8'h10, write data 8'h77, read addr 8'h10, read data against the golden slave with RAM -> rd_data=8'h77.
